// File: rtl/alu_response_checker_if.sv
// Transaction and status bundle between an ALU stimulus/observer side and the response checker.
// The master drives operands, opcode and observed result; the slave (checker) returns run status.
interface alu_response_checker_if;
  logic        start;
  logic        valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  op;
  logic [7:0]  f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] txn_count;
  logic [15:0] err_count;
  logic [7:0]  err_a;
  logic [7:0]  err_b;
  logic [3:0]  err_op;
  logic [7:0]  err_f;
  logic [7:0]  err_exp;
  logic        err_valid;

  modport master (
    output start, valid, a, b, op, f,
    input  busy, done, pass, txn_count, err_count,
    input  err_a, err_b, err_op, err_f, err_exp, err_valid
  );

  modport slave (
    input  start, valid, a, b, op, f,
    output busy, done, pass, txn_count, err_count,
    output err_a, err_b, err_op, err_f, err_exp, err_valid
  );
endinterface

// File: rtl/alu_response_checker.sv
// Checks 8-bit ALU results against a fixed opcode table over a run of NUM_TXN transactions.
// Optional first-mismatch capture is built only when ALU_CHECK_FIRST_ERR_EN is defined.
module alu_response_checker #(
  parameter int unsigned NUM_TXN = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_TXN - 1);

  state_t      state;
  state_t      state_nxt;
  logic        busy;
  logic        done;
  logic        accept;
  logic        clear;
  logic        last_txn;
  logic [15:0] txn_count;
  logic [15:0] err_count;
  logic        vld_p1;
  logic [7:0]  f_p1;
  logic [7:0]  exp_p1;
  logic        mism_p2;

  function automatic logic [7:0] exp_result(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [15:0] prod;
    logic [7:0]  r;
    prod = {8'h00, a} * {8'h00, b};
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = prod[7:0];
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd6:    r = ~(a & b);
      4'd7:    r = ~(a | b);
      4'd8:    r = ~(a ^ b);
      4'd9:    r = ~a;
      4'd10:   r = {a[6:0], 1'b0};
      4'd11:   r = {1'b0, a[7:1]};
      4'd12:   r = {a[6:0], a[7]};
      4'd13:   r = {a[0], a[7:1]};
      4'd14:   r = (a > b) ? 8'h01 : 8'h00;
      default: r = (a == b) ? 8'h01 : 8'h00;
    endcase
    return r;
  endfunction

  assign accept   = (state == S_RUN) && bus.valid;
  assign clear    = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
  assign last_txn = accept && (txn_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last_txn)  state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (bus.start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      txn_count <= 16'd0;
    else if (clear)  txn_count <= 16'd0;
    else if (accept) txn_count <= txn_count + 16'd1;
  end

  // Stage 1: register the accepted transaction and its expected result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      f_p1   <= bus.f;
      exp_p1 <= exp_result(bus.a, bus.b, bus.op);
    end
  end

  // Stage 2: compare and count mismatches
  assign mism_p2 = vld_p1 && (f_p1 != exp_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_count <= 16'd0;
    else if (clear)                              err_count <= 16'd0;
    else if (mism_p2 && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = done && (err_count == 16'd0);
  assign bus.txn_count = txn_count;
  assign bus.err_count = err_count;

`ifdef ALU_CHECK_FIRST_ERR_EN
  logic [7:0] a_p1;
  logic [7:0] b_p1;
  logic [3:0] op_p1;
  logic [7:0] err_a_q;
  logic [7:0] err_b_q;
  logic [3:0] err_op_q;
  logic [7:0] err_f_q;
  logic [7:0] err_exp_q;
  logic       err_valid_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= bus.a;
      b_p1  <= bus.b;
      op_p1 <= bus.op;
    end
  end

  // Only the first mismatch of a run is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_a_q     <= 8'h00;
      err_b_q     <= 8'h00;
      err_op_q    <= 4'h0;
      err_f_q     <= 8'h00;
      err_exp_q   <= 8'h00;
    end else if (clear) begin
      err_valid_q <= 1'b0;
      err_a_q     <= 8'h00;
      err_b_q     <= 8'h00;
      err_op_q    <= 4'h0;
      err_f_q     <= 8'h00;
      err_exp_q   <= 8'h00;
    end else if (mism_p2 && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_a_q     <= a_p1;
      err_b_q     <= b_p1;
      err_op_q    <= op_p1;
      err_f_q     <= f_p1;
      err_exp_q   <= exp_p1;
    end
  end

  assign bus.err_valid = err_valid_q;
  assign bus.err_a     = err_a_q;
  assign bus.err_b     = err_b_q;
  assign bus.err_op    = err_op_q;
  assign bus.err_f     = err_f_q;
  assign bus.err_exp   = err_exp_q;
`else
  assign bus.err_valid = 1'b0;
  assign bus.err_a     = 8'h00;
  assign bus.err_b     = 8'h00;
  assign bus.err_op    = 4'h0;
  assign bus.err_f     = 8'h00;
  assign bus.err_exp   = 8'h00;
`endif

endmodule

// File: tb/tb_alu_response_checker.sv
// Self-checking bench for alu_response_checker: directed vector table, corner sequences
// and randomized runs scored against an arithmetic reference model.
module tb_alu_response_checker;
  localparam int N = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] f;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[20];
  vec_t cur[N];

  always #5 clk = ~clk;

  alu_response_checker_if bus();

  alu_response_checker #(.NUM_TXN(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Opcode table evaluated with plain integer arithmetic on 0..255 values
  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      2:  return (a * b) % 256;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return 255 - (a & b);
      7:  return 255 - (a | b);
      8:  return 255 - (a ^ b);
      9:  return 255 - a;
      10: return (a * 2) % 256;
      11: return a / 2;
      12: return (a * 2) % 256 + a / 128;
      13: return a / 2 + (a % 2) * 128;
      14: return (a > b) ? 1 : 0;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_txn"}, 32'(bus.txn_count), 0);
    check({tag, "_err"}, 32'(bus.err_count), 0);
    check({tag, "_errv"}, 32'(bus.err_valid), 0);
    check({tag, "_errcap"}, {bus.err_a, bus.err_b, bus.err_f, bus.err_exp} ^ 32'(bus.err_op), 0);
  endtask

  task automatic run_cur(input string tag, input bit start_in_run, input bit start_in_drain);
    int exp_err;
    int first;
    exp_err = 0;
    first   = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_run"}, 32'(bus.busy), 1);
    check({tag, "_txn_clr"}, 32'(bus.txn_count), 0);
    check({tag, "_err_clr"}, 32'(bus.err_count), 0);
    for (int i = 0; i < N; i++) begin
      bus.valid = 1'b1;
      bus.a     = cur[i].a;
      bus.b     = cur[i].b;
      bus.op    = cur[i].op;
      bus.f     = cur[i].f;
      bus.start = start_in_run ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      check({tag, "_txn_step"}, 32'(bus.txn_count), 32'(i + 1));
      check({tag, "_err_lat"}, 32'(bus.err_count), 32'(exp_err));
      if (cur[i].f != cur[i].exp) begin
        exp_err++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_drain_busy"}, 32'(bus.busy), 1);
    check({tag, "_drain_done"}, 32'(bus.done), 0);
    // Extra valid pulses in DRAIN and DONE must not be counted
    bus.a     = 8'($urandom_range(0, 255));
    bus.f     = 8'($urandom_range(0, 255));
    bus.start = start_in_drain;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_busy_done"}, 32'(bus.busy), 0);
    check({tag, "_txn"}, 32'(bus.txn_count), N);
    check({tag, "_err"}, 32'(bus.err_count), 32'(exp_err));
    check({tag, "_pass"}, 32'(bus.pass), 32'(exp_err == 0));
`ifdef ALU_CHECK_FIRST_ERR_EN
    if (first >= 0) begin
      check({tag, "_errv"}, 32'(bus.err_valid), 1);
      check({tag, "_err_a"}, 32'(bus.err_a), 32'(cur[first].a));
      check({tag, "_err_b"}, 32'(bus.err_b), 32'(cur[first].b));
      check({tag, "_err_op"}, 32'(bus.err_op), 32'(cur[first].op));
      check({tag, "_err_f"}, 32'(bus.err_f), 32'(cur[first].f));
      check({tag, "_err_exp"}, 32'(bus.err_exp), 32'(cur[first].exp));
    end else begin
      check({tag, "_errv"}, 32'(bus.err_valid), 0);
    end
`else
    check({tag, "_errv"}, 32'(bus.err_valid), 0);
    check({tag, "_errcap"}, {bus.err_a, bus.err_b, bus.err_f, bus.err_exp} ^ 32'(bus.err_op), 0);
`endif
    @(posedge clk); #1;
    bus.valid = 1'b0;
    check({tag, "_done_hold"}, 32'(bus.done), 1);
    check({tag, "_txn_hold"}, 32'(bus.txn_count), N);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.valid = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.op = 4'h0;
    bus.f = 8'h00;

    tbl[0]  = '{8'hF0, 8'h20, 4'd0,  8'h10, 8'h10};
    tbl[1]  = '{8'hF0, 8'h20, 4'd1,  8'hD0, 8'hD0};
    tbl[2]  = '{8'hF0, 8'h20, 4'd2,  8'h00, 8'h00};
    tbl[3]  = '{8'hF0, 8'h20, 4'd3,  8'h20, 8'h20};
    tbl[4]  = '{8'h0F, 8'h11, 4'd2,  8'h00, 8'hFF};
    tbl[5]  = '{8'h01, 8'h02, 4'd4,  8'h03, 8'h03};
    tbl[6]  = '{8'h00, 8'h00, 4'd7,  8'hFF, 8'hFF};
    tbl[7]  = '{8'h55, 8'h00, 4'd9,  8'hAA, 8'hAA};
    tbl[8]  = '{8'h3C, 8'h0F, 4'd5,  8'h00, 8'h33};
    tbl[9]  = '{8'h81, 8'h00, 4'd12, 8'h00, 8'h03};
    tbl[10] = '{8'hFF, 8'h0F, 4'd6,  8'hF0, 8'hF0};
    tbl[11] = '{8'hAA, 8'h55, 4'd8,  8'h00, 8'h00};
    tbl[12] = '{8'h81, 8'h00, 4'd10, 8'h02, 8'h02};
    tbl[13] = '{8'h01, 8'h00, 4'd13, 8'h80, 8'h80};
    tbl[14] = '{8'h7F, 8'h7F, 4'd14, 8'h00, 8'h00};
    tbl[15] = '{8'h7F, 8'h7F, 4'd15, 8'h01, 8'h01};
    tbl[16] = '{8'h81, 8'h00, 4'd11, 8'h40, 8'h40};
    tbl[17] = '{8'h00, 8'h01, 4'd1,  8'hFF, 8'hFF};
    tbl[18] = '{8'h80, 8'h7F, 4'd14, 8'h01, 8'h01};
    tbl[19] = '{8'hFF, 8'h01, 4'd0,  8'h00, 8'h00};

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) cur[i] = tbl[r * N + i];
      run_cur($sformatf("tbl%0d", r), r == 3, r == 2);
    end

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        cur[i].a   = 8'($urandom_range(0, 255));
        cur[i].b   = ($urandom_range(0, 3) == 0) ? cur[i].a : 8'($urandom_range(0, 255));
        cur[i].op  = 4'($urandom_range(0, 15));
        cur[i].exp = 8'(ref_alu(int'(cur[i].a), int'(cur[i].b), int'(cur[i].op)));
        cur[i].f   = cur[i].exp;
        if ($urandom_range(0, 3) == 0) cur[i].f = cur[i].exp ^ 8'($urandom_range(1, 255));
      end
      run_cur($sformatf("rnd%0d", r), 1'b1, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run, with a mismatch still in the compare stage
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1;
      bus.a = 8'h10;
      bus.b = 8'h01;
      bus.op = 4'd0;
      bus.f = (i == 0) ? 8'h11 : 8'h00;
      @(posedge clk); #1;
    end
    bus.valid = 1'b0;
    check("mid_txn", 32'(bus.txn_count), 3);
    check("mid_err", 32'(bus.err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("post_rst");
    for (int i = 0; i < N; i++) cur[i] = tbl[i];
    run_cur("after_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_response_checker.md
# alu_response_checker

Synthesizable response checker at the receiving end of the ALU stimulus path. It observes each operand/opcode transaction and the result driven back by the 8-bit ALU under test. It then computes the expected result from a fixed opcode table, counts transactions and mismatches, and reports pass or fail after a programmed number of transactions. It sits beside the ALU in self-checking benches and on-chip BIST wrappers.

## Interface
- `NUM_TXN`, default 1000: number of transactions per run, valid range 1..65535.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that starts a run.
- `valid` input 1: the `a`, `b`, `op` and `f` inputs are a transaction this cycle.
- `a`, `b` input 8 each: operands.
- `op` input 4: opcode.
- `f` input 8: result produced by the ALU under test.
- `busy` output 1: state is RUN or DRAIN.
- `done` output 1: state is DONE; held until the next `start` or reset.
- `pass` output 1: `done` is high and `err_count` is 0.
- `txn_count` output 16: number of accepted transactions.
- `err_count` output 16: number of mismatches; saturates at 16'hFFFF.
- `err_a`, `err_b`, `err_f`, `err_exp` output 8 each: values captured at the first mismatch.
- `err_op` output 4: opcode captured at the first mismatch.
- `err_valid` output 1: the first-mismatch capture is loaded.

## Operation
- Expected-result table. All arithmetic is mod 256 and unsigned.
  - 0: a+b
  - 1: a−b
  - 2: low 8 bits of a*b
  - 3: a&b
  - 4: a|b
  - 5: a^b
  - 6: ~(a&b)
  - 7: ~(a|b)
  - 8: ~(a^b)
  - 9: ~a
  - 10: a<<1
  - 11: a>>1 (logical)
  - 12: rotate a left by 1
  - 13: rotate a right by 1
  - 14: 8'h01 if a>b, else 8'h00
  - 15: 8'h01 if a==b, else 8'h00
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE, or DONE, with `start`=1:
  - clears `txn_count`, `err_count`, `err_valid` and the capture registers;
  - goes to RUN.
- RUN, `valid`=1: accepts the transaction.
  - `txn_count` increments.
  - Stage-1 registers load `a`, `b`, `op`, `f` and the expected value.
- RUN: when an accepted transaction brings `txn_count` to `NUM_TXN`, go to DRAIN.
- DRAIN: lasts one cycle while the last compare completes, then goes to DONE.
- DONE: holds all counts. `done`=1. `pass` is valid.
- `valid` is ignored in IDLE, DRAIN and DONE.
- `start` is ignored in RUN and DRAIN.
- Stage 2 compares the registered `f` against the registered expected value on a stage-1 valid.
  - On a mismatch, `err_count` increments unless it is saturated.
  - On the first mismatch only, `err_*` load the captured values and `err_valid` sets.
- Reset mid-run:
  - all outputs return to their reset values;
  - the pipeline valid is cleared;
  - there is no partial count.

## Timing
- Reset values:
  - all counts 0;
  - all `err_*` 0;
  - `err_valid`, `busy`, `done` and `pass` are 0.
- A transaction is sampled at edge E0.
  - `txn_count` reflects it after E0.
  - `err_count` and the capture registers reflect it after E1.
  - Compare latency is 1 cycle.
- Back-to-back `valid` is supported at 1 transaction per cycle with no stall.
- Last transaction at E0:
  - state is DRAIN after E0;
  - DONE after E1, so `done` and `pass` are visible in the cycle after E1;
  - its compare is included.
- A `start` arriving in the same cycle as the DONE entry is ignored. `start` is accepted from the next cycle onward.

## Configuration
- Macro: `ALU_CHECK_FIRST_ERR_EN`.
- When defined: the first-mismatch capture registers are built, and `err_a`, `err_b`, `err_op`, `err_f`, `err_exp` and `err_valid` behave as described above.
- When undefined: those registers are not built, and those outputs are constant 0.
- Counters, FSM and `pass` are identical in both builds.

## Test plan
- Reset, then RUN with `NUM_TXN`=4 and correct results.
  - Stimulus: a=8'hF0, b=8'h20 for op 0, 1, 2, 3, i.e. f = 10, D0, 00, 20.
  - Required response: `txn_count`=4, `err_count`=0, `done`=1, `pass`=1 two cycles after the last `valid`.
- Single corrupted result: op=2, a=8'h0F, b=8'h11, f=8'h00; the expected value is 8'hFF.
  - Required response: `err_count`=1, `pass`=0.
  - With the macro: err_op=2, err_f=8'h00, err_exp=8'hFF, `err_valid`=1.
  - Without the macro: all `err_*` are 0.
- Two mismatches (op 5, then op 12).
  - Required response: `err_count`=2.
  - With the macro, the capture still holds the op-5 values.
- Back-to-back `valid` for `NUM_TXN` cycles, plus extra `valid` pulses during DRAIN and DONE.
  - Required response: `txn_count` equals `NUM_TXN` exactly; the extra pulses are ignored.
- Assert `rst_n`=0 mid-run after 3 transactions with 1 error.
  - Required response: all outputs are 0 immediately, asynchronously.
  - A following `start` runs cleanly to `pass`=1.
- Boundary ops.
  - Stimulus: op 10 with a=8'h81 -> 02; op 13 with a=8'h01 -> 80; op 14 with a=b=8'h7F -> 00; op 15 with a=b=8'h7F -> 01.
  - Required response: no errors.
